// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       pcen;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, zero,
    output memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca,
    output alusrcb, pcsrc, aluop, state, instr_done, illegal
  );

  modport slave (
    output op, zero,
    input  memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca,
    input  alusrcb, pcsrc, aluop, state, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore FSM controller for a MIPS-style multicycle datapath (lw/sw/R/beq/addi/j).
// Optional macro MULTICYCLE_BNE_EN adds bne (op 000101) through the BRANCH state.
module multicycle_ctrl (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
  localparam logic [5:0] OpBne  = 6'b000101;
`endif

  state_e state_q, state_d;
  logic   op_valid;
  logic   pcwrite, branch, taken;
  logic   memwrite_raw, irwrite_raw, regwrite_raw, done_raw;

  always_comb begin
    op_valid = 1'b0;
    case (bus.op)
      OpLw, OpSw, OpR, OpBeq, OpAddi, OpJ: op_valid = 1'b1;
`ifdef MULTICYCLE_BNE_EN
      OpBne:                               op_valid = 1'b1;
`endif
      default:                             op_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MULTICYCLE_BNE_EN
  // Captured in DECODE so BRANCH can invert the zero test for bne.
  logic bne_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bne_q <= 1'b0;
    end else if (state_q == StDecode) begin
      bne_q <= (bus.op == OpBne);
    end
  end

  assign taken = bus.zero ^ bne_q;
`else
  assign taken = bus.zero;
`endif

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:   state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecute;
          OpBeq:      state_d = StBranch;
`ifdef MULTICYCLE_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (bus.op == OpSw) ? StMemWr : StMemRd;
      StMemRd:   state_d = StMemWb;
      StExecute: state_d = StAluWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    done_raw     = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.aluop    = 2'b00;
    case (state_q)
      StFetch: begin
        bus.alusrcb = 2'b01;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      StDecode: bus.alusrcb = 2'b11;
      StMemAdr, StAddiEx: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      StMemRd: bus.iord = 1'b1;
      StMemWb: begin
        bus.memtoreg = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      StMemWr: begin
        bus.iord     = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      StExecute: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      StAluWb: begin
        bus.regdst   = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      StAddiWb: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      StBranch: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
        done_raw    = 1'b1;
      end
      StJump: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
        done_raw  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables and pulses are gated by reset so nothing fires while it is held low.
  assign bus.memwrite   = memwrite_raw & reset;
  assign bus.irwrite    = irwrite_raw & reset;
  assign bus.regwrite   = regwrite_raw & reset;
  assign bus.pcen       = (pcwrite | (branch & taken)) & reset;
  assign bus.instr_done = done_raw & reset;
  assign bus.illegal    = (state_q == StDecode) & ~op_valid & reset;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] wr_en();
    return {bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    bus.op   = 6'b000000;
    bus.zero = 1'b0;
    #2;
    check("rst_state", bus.state, 4'd0);
    check("rst_wren", wr_en(), 4'b0000);
    check("rst_alusrcb", bus.alusrcb, 2'b01);
    check("rst_pulses", {bus.instr_done, bus.illegal}, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // lw: 0,1,2,3,4,0
    bus.op = 6'b100011;
    check("lw_s0", bus.state, 4'd0);
    check("lw_fetch_en", {bus.irwrite, bus.pcen, bus.regwrite}, 3'b110);
    tick();
    check("lw_s1", bus.state, 4'd1);
    check("lw_dec_srcb", bus.alusrcb, 2'b11);
    tick();
    check("lw_s2", bus.state, 4'd2);
    check("lw_adr_src", {bus.alusrca, bus.alusrcb}, 3'b110);
    tick();
    check("lw_s3", bus.state, 4'd3);
    check("lw_rd_sel", {bus.iord, bus.regwrite, bus.memtoreg}, 3'b100);
    tick();
    check("lw_s4", bus.state, 4'd4);
    check("lw_wb", {bus.regwrite, bus.memtoreg, bus.instr_done}, 3'b111);
    tick();
    check("lw_back", bus.state, 4'd0);
    check("lw_done_clr", bus.instr_done, 1'b0);

    // beq taken then not taken, 3 cycles each
    bus.op = 6'b000100;
    bus.zero = 1'b1;
    tick();
    check("beq1_s1", bus.state, 4'd1);
    check("beq1_pcen_dec", bus.pcen, 1'b0);
    tick();
    check("beq1_s8", bus.state, 4'd8);
    check("beq1_pcen", bus.pcen, 1'b1);
    check("beq1_sel", {bus.alusrca, bus.aluop, bus.pcsrc, bus.instr_done}, 6'b1_01_01_1);
    tick();
    check("beq1_back", bus.state, 4'd0);
    bus.zero = 1'b0;
    tick();
    tick();
    check("beq0_s8", bus.state, 4'd8);
    check("beq0_pcen", bus.pcen, 1'b0);
    tick();
    check("beq0_back", bus.state, 4'd0);

    // illegal opcode
    bus.op = 6'b111111;
    tick();
    check("ill_s1", bus.state, 4'd1);
    check("ill_flag", {bus.illegal, bus.instr_done}, 2'b10);
    check("ill_wren", wr_en(), 4'b0000);
    tick();
    check("ill_back", bus.state, 4'd0);
    check("ill_clr", bus.illegal, 1'b0);

    // bne (op 000101), zero=0
    bus.op = 6'b000101;
    bus.zero = 1'b0;
    tick();
`ifdef MULTICYCLE_BNE_EN
    check("bne_ill", bus.illegal, 1'b0);
    tick();
    check("bne_s8", bus.state, 4'd8);
    check("bne_pcen", bus.pcen, 1'b1);
    tick();
`else
    check("bne_ill", bus.illegal, 1'b1);
    tick();
`endif
    check("bne_back", bus.state, 4'd0);

    // R-type then j: 0,1,6,7,0,1,11,0
    bus.op = 6'b000000;
    tick();
    check("r_s1", bus.state, 4'd1);
    tick();
    check("r_s6", bus.state, 4'd6);
    check("r_aluop", {bus.alusrca, bus.aluop, bus.regwrite}, 4'b1_10_0);
    tick();
    check("r_s7", bus.state, 4'd7);
    check("r_wb", {bus.regdst, bus.regwrite, bus.instr_done}, 3'b111);
    tick();
    check("r_back", bus.state, 4'd0);
    bus.op = 6'b000010;
    tick();
    check("j_s1", bus.state, 4'd1);
    tick();
    check("j_s11", bus.state, 4'd11);
    check("j_pc", {bus.pcsrc, bus.pcen, bus.instr_done}, 4'b10_1_1);
    tick();
    check("j_back", bus.state, 4'd0);

    // addi: 0,1,9,10,0
    bus.op = 6'b001000;
    tick();
    tick();
    check("addi_s9", bus.state, 4'd9);
    check("addi_src", {bus.alusrca, bus.alusrcb}, 3'b110);
    tick();
    check("addi_s10", bus.state, 4'd10);
    check("addi_wb", {bus.regwrite, bus.regdst, bus.memtoreg}, 3'b100);
    tick();
    check("addi_back", bus.state, 4'd0);

    // sw aborted by reset while in MEMWR
    bus.op = 6'b101011;
    tick();
    tick();
    tick();
    check("sw_s5", bus.state, 4'd5);
    check("sw_wr", {bus.memwrite, bus.iord}, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    check("abort_memwrite", bus.memwrite, 1'b0);
    check("abort_state", bus.state, 4'd0);
    check("abort_wren", wr_en(), 4'b0000);
    check("abort_srcb", bus.alusrcb, 2'b01);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_fetch", {bus.state, bus.irwrite}, 5'b0000_1);
    tick();
    check("rel_decode", bus.state, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
